cpucr_bus_ctrl: RTL
===================

Name: cpucr_bus_ctrl

Overview:
- Memory bus controller between the CPUCR core and the main memory.
- Converts a clocked req/ack transaction from the core into the memory's asynchronous protocol: 16-bit Direccion, bidirectional 8-bit Datos, and LE.
- LE=1 means read and the memory drives Datos. A falling edge of LE writes Datos into M[Direccion].
- Owns all address/LE timing, Datos tristate control, read-data capture and wait-state insertion.

Parameters:
- WAIT_CYCLES, 0, extra clocks added to every read access and write strobe; legal range 0..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- req  in  1  core request; sampled only in IDLE.
- we  in  1  1=write, 0=read; sampled with req.
- addr  in  16  byte address; sampled with req.
- wdata  in  8  write data; sampled with req.
- rdata  out  8  read data; valid while ack=1, held until the next read completes.
- ack  out  1  one-clock completion pulse.
- busy  out  1  high from the accepting edge until the edge that raises ack.
- Direccion  out  16  memory address bus, registered.
- LE  out  1  memory read/write strobe, registered.
- Datos  inout  8  memory data bus. Driven with the registered write data only while LE=0, otherwise Z.

Behaviour:
- Reset values: LE=1, Direccion=16'h0000, Datos=Z, rdata=8'h00, ack=0, busy=0, state=IDLE, wait counter=0.
- States: IDLE, RD_ACCESS, WR_SETUP, WR_STROBE, WR_RECOVER.
- IDLE:
  - On req=1, latch addr/we/wdata and drive Direccion with addr on that edge; busy<=1.
  - we=0 goes to RD_ACCESS; we=1 goes to WR_SETUP.
  - req=0 stays in IDLE.
- RD_ACCESS:
  - LE stays 1 for WAIT_CYCLES+1 clocks.
  - On the last edge: rdata<=Datos, ack<=1, busy<=0, go to IDLE.
  - ack is visible WAIT_CYCLES+1 clocks after the accepting edge.
- WR_SETUP:
  - One clock with Direccion stable and LE=1.
  - Next edge: LE<=0, go to WR_STROBE.
- WR_STROBE:
  - LE=0 for WAIT_CYCLES+1 clocks; Datos driven with the latched wdata.
  - Next edge: LE<=1, go to WR_RECOVER.
- WR_RECOVER:
  - One clock with LE=1 and Direccion held.
  - Next edge: ack<=1, busy<=0, go to IDLE.
  - ack is visible WAIT_CYCLES+3 clocks after the accepting edge.
- LE must be glitch-free: exactly one falling edge per write and none per read, since any LE fall writes memory.
- Direccion changes only on the accepting edge, never while LE=0.
- Back-to-back: req=1 during the ack cycle is accepted on that edge, so no idle bubble is required.
- A req held high after ack starts a new transaction with the same sampled inputs.
- req changes while busy are ignored.
- Wait counter loads WAIT_CYCLES on entry to RD_ACCESS/WR_STROBE and decrements to 0. With WAIT_CYCLES=0 these states last exactly one clock.
- Reset mid-operation:
  - Next edge forces the reset values: LE returns to 1, Datos is released, no ack.
  - A write whose LE fall already occurred is not undone.

Optional Feature:
- Macro: CPUCR_BUS_WORD_EN.
- When defined:
  - Adds input size (1=16-bit access, sampled with req).
  - wdata and rdata widen to 16 bits.
  - A word access performs two complete byte transactions: low byte at addr, high byte at addr+1 (16-bit wrap, 16'hFFFF+1=16'h0000), little-endian.
  - busy stays high throughout; a single ack follows the second byte.
  - Word read latency is 2*(WAIT_CYCLES+1); word write latency is 2*(WAIT_CYCLES+3).
  - size=0 behaves exactly as the byte controller, using wdata[7:0] and zero-extending into rdata.
- When undefined: byte-only ports and behaviour as described above.

Test Plan:
- Reset, then hold req=0 for 10 clocks -> LE=1 every cycle, Datos=Z, ack=0, busy=0, Direccion=16'h0000.
- WAIT_CYCLES=0, write addr=16'h1000 wdata=8'h3C -> exactly one LE fall at Direccion=16'h1000, memory M[16'h1000]=8'h3C, ack 3 clocks after accept.
- WAIT_CYCLES=2, read addr=16'h0002 with memory preloaded to 8'h06 -> LE never falls, ack 3 clocks after accept, rdata=8'h06.
- Back-to-back write 16'h0010<=8'hA5 then read 16'h0010, req held high -> second accept on the first ack cycle, rdata=8'hA5, one LE fall total.
- Assert reset during WR_STROBE with WAIT_CYCLES=3 -> next clock LE=1, Datos=Z, busy=0, no ack.
- CPUCR_BUS_WORD_EN defined, word write addr=16'hFFFF wdata=16'hBEEF -> M[16'hFFFF]=8'hEF, M[16'h0000]=8'hBE. Word read of the same address returns rdata=16'hBEEF with a single ack.

Source files
------------

// File: rtl/cpucr_bus_ctrl_if.sv
// cpucr_bus_ctrl_if: core-side request/acknowledge bus of the CPUCR memory
// controller. With CPUCR_BUS_WORD_EN defined the data paths widen to 16 bits
// and a size select is added.
interface cpucr_bus_ctrl_if;
`ifdef CPUCR_BUS_WORD_EN
  localparam int DW = 16;
  logic          size;
`else
  localparam int DW = 8;
`endif
  logic          req;
  logic          we;
  logic [15:0]   addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;

`ifdef CPUCR_BUS_WORD_EN
  modport master (output req, we, size, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, size, addr, wdata, output rdata, ack, busy);
`else
  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
`endif
endinterface

// File: rtl/cpucr_bus_ctrl.sv
// cpucr_bus_ctrl: converts CPUCR req/ack transactions into the asynchronous
// main-memory protocol (Direccion, bidirectional Datos, LE strobe; a falling
// LE edge writes memory). WAIT_CYCLES stretches reads and write strobes.
// Optional macro CPUCR_BUS_WORD_EN adds 16-bit accesses split into two
// little-endian byte transactions (addr, then addr+1 with 16-bit wrap).
module cpucr_bus_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  cpucr_bus_ctrl_if.slave   bus,
  output logic [15:0]       Direccion,
  output logic              LE,
  inout  wire  [7:0]        Datos
);

`ifdef CPUCR_BUS_WORD_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACCESS,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_RECOVER
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [15:0]   r_dir;
  logic          r_le;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_ack;
  logic          r_busy;
  logic [7:0]    w_wbyte;
`ifdef CPUCR_BUS_WORD_EN
  logic          r_size;
  logic          r_hi;
  logic [7:0]    r_rdlo;

  assign w_wbyte = r_hi ? r_wdata[15:8] : r_wdata[7:0];
`else
  assign w_wbyte = r_wdata;
`endif

  // LE is a flop output, so the bus enable can never glitch
  assign Datos     = (!r_le) ? w_wbyte : 8'bz;
  assign Direccion = r_dir;
  assign LE        = r_le;
  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;

  // Transaction sequencer: all bus timing, capture and handshake outputs are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dir   <= 16'h0000;
      r_le    <= 1'b1;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef CPUCR_BUS_WORD_EN
      r_size  <= 1'b0;
      r_hi    <= 1'b0;
      r_rdlo  <= 8'h00;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_dir   <= bus.addr;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            r_cnt   <= LP_WAIT;
`ifdef CPUCR_BUS_WORD_EN
            r_size  <= bus.size;
            r_hi    <= 1'b0;
`endif
            r_state <= bus.we ? S_WR_SETUP : S_RD_ACCESS;
          end
        end
        S_RD_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
`ifdef CPUCR_BUS_WORD_EN
            if (r_size && !r_hi) begin
              // Low byte done; address moves while LE is still high
              r_rdlo <= Datos;
              r_dir  <= r_dir + 16'd1;
              r_hi   <= 1'b1;
              r_cnt  <= LP_WAIT;
            end else begin
              r_rdata <= r_size ? {Datos, r_rdlo} : {8'h00, Datos};
              r_ack   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
`else
            r_rdata <= Datos;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end
        end
        S_WR_SETUP: begin
          r_le    <= 1'b0;
          r_cnt   <= LP_WAIT;
          r_state <= S_WR_STROBE;
        end
        S_WR_STROBE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_le    <= 1'b1;
            r_state <= S_WR_RECOVER;
          end
        end
        S_WR_RECOVER: begin
`ifdef CPUCR_BUS_WORD_EN
          if (r_size && !r_hi) begin
            r_dir   <= r_dir + 16'd1;
            r_hi    <= 1'b1;
            r_state <= S_WR_SETUP;
          end else begin
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`else
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
